// File: rtl/avg_arbiter.sv
// avg_arbiter: two-channel block-averaging scheduler.
// One adder is shared between two signed sample streams through a
// round-robin arbiter. Each channel keeps its own accumulator and window
// counter. One floor average is emitted per channel every 2^SAMPLES
// accepted samples, through a single valid/ready port tagged by channel.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i             1 = accept samples; deassert to drain and stop
//   chN_valid_i/data_i  channel N sample stream (signed)
//   chN_ready_o         channel N sample accepted when high with valid
//   avg_valid_o/ch_o    result valid and its channel
//   avg_data_o          signed floor average of the window
//   avg_ready_i         downstream accepts the result
//   busy_o              high while running or draining
module avg_arbiter #(
  parameter int WIDTH   = 16,
  parameter int SAMPLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    ch0_valid_i,
  input  logic signed [WIDTH-1:0] ch0_data_i,
  output logic                    ch0_ready_o,
  input  logic                    ch1_valid_i,
  input  logic signed [WIDTH-1:0] ch1_data_i,
  output logic                    ch1_ready_o,
  output logic                    avg_valid_o,
  output logic                    avg_ch_o,
  output logic signed [WIDTH-1:0] avg_data_o,
  input  logic                    avg_ready_i,
  output logic                    busy_o
);

  localparam int ACC_W = WIDTH + SAMPLES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   last_grant_reg;

  logic [1:0]              valid_vec;
  logic [1:0]              last_vec;
  logic [1:0]              block_vec;
  logic [1:0]              elig_vec;
  logic [1:0]              ready_vec;
  logic [1:0]              accept_vec;
  logic signed [WIDTH-1:0] data_vec [2];
  logic signed [ACC_W-1:0] ext_vec  [2];
  logic signed [ACC_W-1:0] sum_vec  [2];
  logic signed [ACC_W-1:0] acc_reg  [2];
  logic [SAMPLES-1:0]      cnt_reg  [2];

  logic                    grant;
  logic                    out_busy;
  logic                    drain_done;
  logic                    clear_all;
  logic                    accept_any;
  logic                    accept_ch;
  logic                    complete;
  logic signed [ACC_W-1:0] sum_sel;
  logic signed [WIDTH-1:0] avg_val;
  logic                    unused_low;

  assign valid_vec   = {ch1_valid_i, ch0_valid_i};
  assign data_vec[0] = ch0_data_i;
  assign data_vec[1] = ch1_data_i;

  // Output register holds a result that will not leave this cycle.
  assign out_busy   = avg_valid_o & ~avg_ready_i;
  assign drain_done = ~avg_valid_o | avg_ready_i;
  assign clear_all  = (state_reg == ST_DRAIN) & drain_done;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      assign ext_vec[gi]  = {{SAMPLES{data_vec[gi][WIDTH-1]}}, data_vec[gi]};
      assign sum_vec[gi]  = acc_reg[gi] + ext_vec[gi];
      assign last_vec[gi] = (cnt_reg[gi] == {SAMPLES{1'b1}});
      // A channel about to complete cannot be served while the output
      // register is stuck; the other channel keeps flowing meanwhile.
      assign block_vec[gi] = last_vec[gi] & out_busy;
      assign elig_vec[gi]  = valid_vec[gi] & ~block_vec[gi];
      assign ready_vec[gi] = (state_reg == ST_RUN) & elig_vec[gi] &
                             (grant == (gi == 1));

      always_ff @(posedge clk) begin
        if (rst || clear_all) begin
          acc_reg[gi] <= '0;
          cnt_reg[gi] <= '0;
        end else if (accept_vec[gi]) begin
          if (last_vec[gi]) begin
            acc_reg[gi] <= '0;
            cnt_reg[gi] <= '0;
          end else begin
            acc_reg[gi] <= sum_vec[gi];
            cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
          end
        end
      end
    end
  endgenerate

  // Round robin among eligible requesters; ties go to the channel that
  // was not served last.
  always_comb begin
    grant = 1'b0;
    if (elig_vec == 2'b11) begin
      grant = ~last_grant_reg;
    end else if (elig_vec[1]) begin
      grant = 1'b1;
    end
  end

  assign ch0_ready_o = ready_vec[0];
  assign ch1_ready_o = ready_vec[1];
  assign accept_vec  = ready_vec & valid_vec;
  assign accept_any  = |accept_vec;
  assign accept_ch   = accept_vec[1];
  assign complete    = accept_any & last_vec[accept_ch];

  // Dropping the low SAMPLES bits of the full sum is an arithmetic shift,
  // i.e. floor toward minus infinity; the rest fits WIDTH exactly.
  assign sum_sel    = sum_vec[accept_ch];
  assign avg_val    = sum_sel[ACC_W-1:SAMPLES];
  assign unused_low = ^sum_sel[SAMPLES-1:0];

  assign busy_o = (state_reg != ST_IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_i)    state_next = ST_RUN;
      ST_RUN:   if (!start_i)   state_next = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= 1'b1;
      avg_valid_o    <= 1'b0;
      avg_ch_o       <= 1'b0;
      avg_data_o     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept_any) begin
        last_grant_reg <= accept_ch;
      end
      // A completion is only possible when the register is free or being
      // emptied this cycle, so loading never overwrites a live result.
      if (complete) begin
        avg_valid_o <= 1'b1;
        avg_ch_o    <= accept_ch;
        avg_data_o  <= avg_val;
      end else if (avg_valid_o && avg_ready_i) begin
        avg_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avg_arbiter.sv
// Self-checking bench for avg_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level model and an
// output scoreboard.
module tb_avg_arbiter;

  localparam int WIDTH   = 16;
  localparam int SAMPLES = 3;
  localparam int NW      = 1 << SAMPLES;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start_i;
  logic                    ch0_valid_i;
  logic signed [WIDTH-1:0] ch0_data_i;
  logic                    ch0_ready_o;
  logic                    ch1_valid_i;
  logic signed [WIDTH-1:0] ch1_data_i;
  logic                    ch1_ready_o;
  logic                    avg_valid_o;
  logic                    avg_ch_o;
  logic signed [WIDTH-1:0] avg_data_o;
  logic                    avg_ready_i;
  logic                    busy_o;

  avg_arbiter #(.WIDTH(WIDTH), .SAMPLES(SAMPLES)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .ch0_valid_i(ch0_valid_i), .ch0_data_i(ch0_data_i), .ch0_ready_o(ch0_ready_o),
    .ch1_valid_i(ch1_valid_i), .ch1_data_i(ch1_data_i), .ch1_ready_o(ch1_ready_o),
    .avg_valid_o(avg_valid_o), .avg_ch_o(avg_ch_o), .avg_data_o(avg_data_o),
    .avg_ready_i(avg_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  typedef struct {
    bit ch;
    int data;
  } res_t;
  res_t exp_q[$];
  res_t mon_e;

  // Model: 0 idle, 1 run, 2 drain; per-channel sample lists reduced to
  // running sums and counts.
  int     m_state;
  bit     m_last;
  bit     m_occ;
  int     m_cnt [2];
  longint m_sum [2];
  bit     prev_rst = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int floor_avg(input longint s);
    if (s >= 0) return int'(s / NW);
    else        return -int'(((-s) + NW - 1) / NW);
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_last  = 1'b1;
    m_occ   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_sum[i] = 0;
    end
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs, check ready/valid/busy against the
  // model, then advance the model past the next rising edge.
  task automatic step(input bit r, input bit st, input bit v0, input int d0,
                      input bit v1, input int d1, input bit rdy);
    bit   vv [2];
    int   dd [2];
    bit   er [2];
    bit   el [2];
    bit   stuck;
    bit   hs;
    bit   done;
    bit   drain_ok;
    int   n;
    res_t r_e;
    @(posedge clk);
    #1;
    rst = r; start_i = st; avg_ready_i = rdy;
    ch0_valid_i = v0; ch0_data_i = 16'(d0);
    ch1_valid_i = v1; ch1_data_i = 16'(d1);
    #3;
    if (r) begin
      model_reset();
    end else begin
      if (prev_rst) begin
        check("reset_avg_data", avg_data_o, 0);
        check("reset_avg_ch", avg_ch_o, 0);
      end
      vv[0] = v0; vv[1] = v1;
      dd[0] = d0; dd[1] = d1;
      check("busy", busy_o, m_state != 0);
      check("avg_valid", avg_valid_o, m_occ);
      stuck = m_occ && !rdy;
      er[0] = 1'b0; er[1] = 1'b0;
      if (m_state == 1) begin
        for (int i = 0; i < 2; i++)
          el[i] = vv[i] && !(m_cnt[i] == NW - 1 && stuck);
        if (el[0] && el[1]) er[m_last ? 0 : 1] = 1'b1;
        else if (el[0])     er[0] = 1'b1;
        else if (el[1])     er[1] = 1'b1;
      end
      if (vv[0] || m_state != 1) check("ch0_ready", ch0_ready_o, er[0]);
      if (vv[1] || m_state != 1) check("ch1_ready", ch1_ready_o, er[1]);

      hs       = m_occ && rdy;
      drain_ok = !m_occ || rdy;
      done     = 1'b0;
      if (er[0] || er[1]) begin
        n = er[1] ? 1 : 0;
        m_last = (n == 1);
        m_sum[n] += dd[n];
        m_cnt[n]++;
        if (m_cnt[n] == NW) begin
          r_e.ch   = (n == 1);
          r_e.data = floor_avg(m_sum[n]);
          exp_q.push_back(r_e);
          m_sum[n] = 0;
          m_cnt[n] = 0;
          done = 1'b1;
        end
      end
      case (m_state)
        0: if (st) m_state = 1;
        1: if (!st) m_state = 2;
        default: if (drain_ok) begin
          m_state = 0;
          for (int i = 0; i < 2; i++) begin
            m_sum[i] = 0;
            m_cnt[i] = 0;
          end
        end
      endcase
      if (done)    m_occ = 1'b1;
      else if (hs) m_occ = 1'b0;
    end
    prev_rst = r;
  endtask

  // Scoreboard monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (!rst && avg_valid_o && avg_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got ch=%0d data=%0d expected none", avg_ch_o, avg_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("avg_ch", avg_ch_o, mon_e.ch);
        check("avg_data", avg_data_o, mon_e.data);
        n_out++;
      end
    end
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; avg_ready_i = 1'b0;
    ch0_valid_i = 1'b0; ch0_data_i = '0;
    ch1_valid_i = 1'b0; ch1_data_i = '0;
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Single channel window of 100.
    step(0, 1, 0, 0, 0, 0, 1);
    repeat (8) step(0, 1, 1, 100, 0, 0, 1);
    repeat (3) step(0, 1, 0, 0, 0, 0, 1);

    // Floor rounding and full-scale extremes.
    for (int i = 1; i <= 8; i++) step(0, 1, 1, -i, 0, 0, 1);
    repeat (2) step(0, 1, 0, 0, 0, 0, 1);
    repeat (8) step(0, 1, 1, 32767, 0, 0, 1);
    repeat (2) step(0, 1, 0, 0, 0, 0, 1);
    repeat (8) step(0, 1, 1, -32768, 0, 0, 1);
    repeat (2) step(0, 1, 0, 0, 0, 0, 1);

    // Both channels contending, results back to back.
    repeat (16) step(0, 1, 1, 10, 1, -20, 1);
    repeat (3) step(0, 1, 0, 0, 0, 0, 1);

    // Backpressure: pending ch0 result blocks ch1 at its final sample.
    repeat (19) step(0, 1, 1, 4, 1, -3, 0);
    repeat (6) step(0, 1, 1, 4, 1, -3, 1);
    repeat (3) step(0, 1, 0, 0, 0, 0, 1);

    // Drain with a pending ch1 result and a partial ch0 window.
    repeat (8) step(0, 1, 0, 0, 1, 9, 0);
    repeat (3) step(0, 1, 1, 77, 0, 0, 0);
    repeat (4) step(0, 0, 1, 77, 1, 9, 0);
    step(0, 1, 1, 77, 1, 9, 0);
    repeat (2) step(0, 1, 0, 0, 0, 0, 1);
    repeat (8) step(0, 1, 1, 50, 0, 0, 1);
    repeat (3) step(0, 1, 0, 0, 0, 0, 1);

    // Reset mid-window, then a clean window of 7.
    repeat (5) step(0, 1, 0, 0, 1, 3, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    repeat (8) step(0, 1, 0, 0, 1, 7, 1);
    repeat (3) step(0, 1, 0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      step(0, $urandom_range(0, 99) < 97,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 99) < 70);
    end

    repeat (10) step(0, 0, 0, 0, 0, 0, 1);
    check("pending_results", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avg_arbiter.md
Name: avg_arbiter

Overview:
Two-channel block-averaging scheduler for the FM demodulator's post-detection path. It shares one adder between two sample streams (I/Q, or two demod outputs) through a round-robin arbiter, keeps a private accumulator and window counter per channel, and emits one decimated average per channel every 2^SAMPLES accepted samples. Results leave through a single valid/ready output port tagged with the channel number.

Parameters:
WIDTH, 16, signed sample width of inputs and output.
SAMPLES, 3, log2 of the averaging window (window N = 2^SAMPLES = 8 by default).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start_i  input  1  enable; 1 = accept samples, falling edge = drain and stop.
ch0_valid_i  input  1  channel 0 sample valid.
ch0_data_i  input  WIDTH  channel 0 sample, signed.
ch0_ready_o  output  1  channel 0 sample accepted this cycle when high with ch0_valid_i.
ch1_valid_i  input  1  channel 1 sample valid.
ch1_data_i  input  WIDTH  channel 1 sample, signed.
ch1_ready_o  output  1  channel 1 sample accepted this cycle when high with ch1_valid_i.
avg_valid_o  output  1  average available.
avg_ch_o  output  1  channel of avg_data_o.
avg_data_o  output  WIDTH  signed average.
avg_ready_i  input  1  downstream accepts average.
busy_o  output  1  high in RUN or DRAIN.

Behaviour:
- Clock and reset: clk only; rst is synchronous and active-high. Reset clears all outputs to 0, both accumulators and counters to 0, sets state to IDLE and last_grant to 1, so ch0 wins the first contention.
- FSM states:
  - IDLE: no ready; go to RUN when start_i=1.
  - RUN: arbitrate and accumulate; go to DRAIN when start_i=0.
  - DRAIN: no ready; stay until avg_valid_o=0 (or handshake completes this cycle), then clear both accumulators and counters and go to IDLE. A partial window is discarded, never output.
- Grant (combinational, RUN only):
  - Only one requester valid: that channel is granted.
  - Both valid: the channel != last_grant is granted.
  - chN_ready_o = RUN & grant==N & ~blockN.
  - last_grant updates only on an accepted sample.
- Block rule: blockN = 1 when counter N == N-1 and the output register is occupied and not being drained this cycle (avg_valid_o & ~avg_ready_i). In that case the grant passes to the other channel if it is valid, so there is no deadlock and no stall of the other channel.
- Accumulate:
  - Accumulators are signed, WIDTH+SAMPLES bits, sign-extended adds, no overflow possible.
  - On acceptance with counter < N-1: acc += sample, counter += 1.
  - On acceptance with counter == N-1:
    - avg_data_o <= (acc + sample) >>> SAMPLES, an arithmetic shift that floors toward minus infinity, low WIDTH bits.
    - avg_ch_o <= N, avg_valid_o <= 1.
    - acc <= 0, counter <= 0.
- Latency: avg_valid_o rises on the edge that accepts the window's final sample (one cycle after the handshake cycle's data is presented).
- Output handshake: avg_valid_o/avg_ch_o/avg_data_o hold stable until avg_valid_o & avg_ready_i. Handshake plus a new completion in the same cycle loads the new result, keeping avg_valid_o=1 with no bubble. Handshake alone clears avg_valid_o.
- busy_o = (state != IDLE).
- start_i reasserted during DRAIN is ignored until IDLE is reached; the next cycle then enters RUN.
- rst mid-window or mid-handshake: immediate clear as above; the pending average is lost.

Test Plan:
1. Reset, start_i=1, ch0 valid with eight samples of 100, ch1 idle, avg_ready_i=1 -> ch0_ready_o high each cycle; the cycle after the 8th acceptance gives avg_valid_o=1, avg_ch_o=0, avg_data_o=100, for one cycle only.
2. ch0 samples -1,-2,...,-8 (sum -36) -> avg_data_o=-5 (floor of -4.5). Eight samples of 32767 -> 32767. Eight samples of -32768 -> -32768.
3. Both channels valid continuously, ch0=10, ch1=-20, avg_ready_i=1 -> grants alternate ch0,ch1,... starting with ch0. ch0 average 10 is output after the 15th acceptance and ch1 average -20 in the next cycle, back-to-back with no bubble.
4. Backpressure: avg_ready_i=0 with the ch0 result pending and ch1 at count 7 -> ch1_ready_o held low while ch0 keeps being accepted. Raising avg_ready_i -> ch0 result consumed, then ch1 completes and its average appears.
5. start_i dropped after 3 ch0 samples with a ch1 result pending, avg_ready_i=0 for 4 cycles -> both readies 0 and busy_o=1 until the handshake, then IDLE. On restart, a fresh 8-sample window of 50 outputs 50 (the partial ch0 sum is discarded).
6. rst pulsed for one cycle after 5 ch1 samples -> all outputs 0 the next cycle. A subsequent full window of 7 outputs exactly 7.
